// File: rtl/packetfilt_sched.sv
`default_nettype none
// ============================================================================
// Module   : packetfilt_sched
// Brief    : Round-robin scheduler that multiplexes one snooper and one forwarder
//            across N_FILTERS packetfilt instances (strobes/dones/read data only).
//            Optional counters: define PACKETFILT_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module packetfilt_sched #(
    parameter int N_FILTERS            = 4,
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH           = 64
) (
    input  logic                                           axi_aclk,
    input  logic                                           rst,
    input  logic                                           snooper_wr_en,
    input  logic                                           snooper_done,
    output logic                                           ready_for_snooper,
    input  logic                                           forwarder_rd_en,
    input  logic                                           forwarder_done,
    output logic [DATA_WIDTH-1:0]                          forwarder_rd_data,
    output logic                                           ready_for_forwarder,
    output logic [SNOOP_FWD_ADDR_WIDTH:0]                  len_to_forwarder,
`ifdef PACKETFILT_SCHED_STATS_EN
    output logic [31:0]                                    pkts_dispatched,
    output logic [31:0]                                    pkts_forwarded,
`endif
    output logic [N_FILTERS-1:0]                           flt_wr_en,
    output logic [N_FILTERS-1:0]                           flt_snooper_done,
    input  logic [N_FILTERS-1:0]                           flt_ready_for_snooper,
    output logic [N_FILTERS-1:0]                           flt_rd_en,
    output logic [N_FILTERS-1:0]                           flt_forwarder_done,
    input  logic [N_FILTERS-1:0]                           flt_ready_for_forwarder,
    input  logic [N_FILTERS*DATA_WIDTH-1:0]                flt_rd_data,
    input  logic [N_FILTERS*(SNOOP_FWD_ADDR_WIDTH+1)-1:0]  flt_len
);

    localparam int PLEN = SNOOP_FWD_ADDR_WIDTH + 1;
    localparam int SELW = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;

    typedef enum logic [0:0] {IN_IDLE = 1'b0, IN_FILL  = 1'b1} in_state_t;
    typedef enum logic [0:0] {EG_IDLE = 1'b0, EG_GRANT = 1'b1} eg_state_t;

    in_state_t       r_in_state, w_in_next;
    eg_state_t       r_eg_state, w_eg_next;
    logic [SELW-1:0] r_in_sel, r_in_ptr, r_eg_sel, r_eg_ptr;

    // First requester strictly after ptr, wrapping; the last served filter ranks lowest.
    function automatic logic [SELW-1:0] rr_pick(input logic [N_FILTERS-1:0] req,
                                                input logic [SELW-1:0]      ptr);
        logic [SELW-1:0] sel;
        int              idx;
        sel = '0;
        for (int k = N_FILTERS; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_FILTERS) idx = idx - N_FILTERS;
            if (req[idx]) sel = SELW'(idx);
        end
        return sel;
    endfunction

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_in_state <= IN_IDLE;
            r_in_ptr   <= SELW'(N_FILTERS - 1);
            r_in_sel   <= '0;
        end else begin
            r_in_state <= w_in_next;
            if (r_in_state == IN_IDLE && |flt_ready_for_snooper)
                r_in_sel <= rr_pick(flt_ready_for_snooper, r_in_ptr);
            if (r_in_state == IN_FILL && snooper_done)
                r_in_ptr <= r_in_sel;
        end
    end

    // Outputs are also gated by rst so an in-flight done cannot leak during reset.
    always_comb begin
        w_in_next         = r_in_state;
        ready_for_snooper = 1'b0;
        flt_wr_en         = '0;
        flt_snooper_done  = '0;
        case (r_in_state)
            IN_IDLE: begin
                if (|flt_ready_for_snooper) w_in_next = IN_FILL;
            end
            IN_FILL: begin
                if (!rst) begin
                    ready_for_snooper          = 1'b1;
                    flt_wr_en[r_in_sel]        = snooper_wr_en;
                    flt_snooper_done[r_in_sel] = snooper_done;
                end
                if (snooper_done) w_in_next = IN_IDLE;
            end
            default: w_in_next = IN_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_eg_state <= EG_IDLE;
            r_eg_ptr   <= SELW'(N_FILTERS - 1);
            r_eg_sel   <= '0;
        end else begin
            r_eg_state <= w_eg_next;
            if (r_eg_state == EG_IDLE && |flt_ready_for_forwarder)
                r_eg_sel <= rr_pick(flt_ready_for_forwarder, r_eg_ptr);
            if (r_eg_state == EG_GRANT && forwarder_done)
                r_eg_ptr <= r_eg_sel;
        end
    end

    always_comb begin
        w_eg_next           = r_eg_state;
        ready_for_forwarder = 1'b0;
        len_to_forwarder    = '0;
        forwarder_rd_data   = '0;
        flt_rd_en           = '0;
        flt_forwarder_done  = '0;
        case (r_eg_state)
            EG_IDLE: begin
                if (|flt_ready_for_forwarder) w_eg_next = EG_GRANT;
            end
            EG_GRANT: begin
                if (!rst) begin
                    ready_for_forwarder          = 1'b1;
                    flt_rd_en[r_eg_sel]          = forwarder_rd_en;
                    flt_forwarder_done[r_eg_sel] = forwarder_done;
                    for (int i = 0; i < N_FILTERS; i++) begin
                        if (r_eg_sel == SELW'(i)) begin
                            len_to_forwarder  = flt_len[i*PLEN +: PLEN];
                            forwarder_rd_data = flt_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                if (forwarder_done) w_eg_next = EG_IDLE;
            end
            default: w_eg_next = EG_IDLE;
        endcase
    end

`ifdef PACKETFILT_SCHED_STATS_EN
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            pkts_dispatched <= '0;
            pkts_forwarded  <= '0;
        end else begin
            if (r_in_state == IN_FILL && snooper_done)   pkts_dispatched <= pkts_dispatched + 32'd1;
            if (r_eg_state == EG_GRANT && forwarder_done) pkts_forwarded  <= pkts_forwarded + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_packetfilt_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_packetfilt_sched
// Brief    : Directed vector bench for packetfilt_sched (N_FILTERS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packetfilt_sched;

    localparam int N    = 4;
    localparam int AW   = 9;
    localparam int DW   = 64;
    localparam int PLEN = AW + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            snooper_wr_en, snooper_done, ready_for_snooper;
    logic            forwarder_rd_en, forwarder_done, ready_for_forwarder;
    logic [DW-1:0]   forwarder_rd_data;
    logic [PLEN-1:0] len_to_forwarder;
    logic [N-1:0]    flt_wr_en, flt_snooper_done, flt_ready_for_snooper;
    logic [N-1:0]    flt_rd_en, flt_forwarder_done, flt_ready_for_forwarder;
    logic [N*DW-1:0] flt_rd_data;
    logic [N*PLEN-1:0] flt_len;
`ifdef PACKETFILT_SCHED_STATS_EN
    logic [31:0]     pkts_dispatched, pkts_forwarded;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    packetfilt_sched #(.N_FILTERS(N), .SNOOP_FWD_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .axi_aclk                (clk),
        .rst                     (rst),
        .snooper_wr_en           (snooper_wr_en),
        .snooper_done            (snooper_done),
        .ready_for_snooper       (ready_for_snooper),
        .forwarder_rd_en         (forwarder_rd_en),
        .forwarder_done          (forwarder_done),
        .forwarder_rd_data       (forwarder_rd_data),
        .ready_for_forwarder     (ready_for_forwarder),
        .len_to_forwarder        (len_to_forwarder),
`ifdef PACKETFILT_SCHED_STATS_EN
        .pkts_dispatched         (pkts_dispatched),
        .pkts_forwarded          (pkts_forwarded),
`endif
        .flt_wr_en               (flt_wr_en),
        .flt_snooper_done        (flt_snooper_done),
        .flt_ready_for_snooper   (flt_ready_for_snooper),
        .flt_rd_en               (flt_rd_en),
        .flt_forwarder_done      (flt_forwarder_done),
        .flt_ready_for_forwarder (flt_ready_for_forwarder),
        .flt_rd_data             (flt_rd_data),
        .flt_len                 (flt_len)
    );

    typedef struct {
        logic       rst, wr, sd;
        logic [3:0] rs;
        logic       rd, fd;
        logic [3:0] rf;
        int         ins;   // expected ingress filter (-1: ingress idle)
        int         egs;   // expected egress filter (-1: egress idle)
    } vec_t;

    vec_t tbl[$];
    logic [PLEN-1:0] lens [N] = '{10'h010, 10'h020, 10'h030, 10'h040};

    function automatic logic [DW-1:0] slice_of(input int i);
        return {32'hDA7A_0000 + 32'(i), 32'(i * 7 + 3)};
    endfunction

    task automatic add(input logic r, input logic w, input logic s, input logic [3:0] rs_v,
                       input logic d, input logic f, input logic [3:0] rf_v,
                       input int ins, input int egs);
        vec_t v;
        v.rst = r; v.wr = w; v.sd = s; v.rs = rs_v; v.rd = d; v.fd = f; v.rf = rf_v;
        v.ins = ins; v.egs = egs;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; snooper_wr_en = v.wr; snooper_done = v.sd; flt_ready_for_snooper = v.rs;
        forwarder_rd_en = v.rd; forwarder_done = v.fd; flt_ready_for_forwarder = v.rf;
    endtask

    function automatic logic [91:0] expect_vec(input vec_t v);
        logic [3:0] wr_m, sd_m, rd_m, fd_m;
        logic       rfs, rff;
        logic [PLEN-1:0] ln;
        logic [DW-1:0]   dt;
        wr_m = '0; sd_m = '0; rd_m = '0; fd_m = '0; rfs = 1'b0; rff = 1'b0; ln = '0; dt = '0;
        if (v.ins >= 0) begin
            rfs = 1'b1;
            wr_m[v.ins] = v.wr;
            sd_m[v.ins] = v.sd;
        end
        if (v.egs >= 0) begin
            rff = 1'b1;
            rd_m[v.egs] = v.rd;
            fd_m[v.egs] = v.fd;
            ln = lens[v.egs];
            dt = slice_of(v.egs);
        end
        return {rfs, wr_m, sd_m, rff, rd_m, fd_m, ln, dt};
    endfunction

    function automatic logic [91:0] actual_vec();
        return {ready_for_snooper, flt_wr_en, flt_snooper_done, ready_for_forwarder,
                flt_rd_en, flt_forwarder_done, len_to_forwarder, forwarder_rd_data};
    endfunction

    task automatic check(input string name, input logic [91:0] act, input logic [91:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < N; i++) begin
            flt_rd_data[i*DW +: DW] = slice_of(i);
            flt_len[i*PLEN +: PLEN] = lens[i];
        end
        v = '{rst: 1'b1, wr: 1'b0, sd: 1'b0, rs: 4'h0, rd: 1'b0, fd: 1'b0, rf: 4'h0, ins: -1, egs: -1};
        drive(v);
        repeat (2) @(negedge clk);

        // Four packets, all filters ready: served 0,1,2,3
        add(0,0,0,4'hF,0,0,4'h0,-1,-1);
        add(0,1,0,4'hF,0,0,4'h0, 0,-1);
        add(0,1,0,4'hF,0,0,4'h0, 0,-1);
        add(0,1,0,4'hF,0,0,4'h0, 0,-1);
        add(0,0,1,4'hF,0,0,4'h0, 0,-1);
        add(0,0,0,4'hF,0,0,4'h0,-1,-1);
        add(0,1,0,4'hF,0,0,4'h0, 1,-1);
        add(0,0,1,4'hF,0,0,4'h0, 1,-1);
        add(0,0,0,4'hF,0,0,4'h0,-1,-1);
        add(0,1,0,4'hF,0,0,4'h0, 2,-1);
        add(0,0,1,4'hF,0,0,4'h0, 2,-1);
        add(0,0,0,4'hF,0,0,4'h0,-1,-1);
        add(0,1,0,4'hF,0,0,4'h0, 3,-1);
        add(0,0,1,4'hF,0,0,4'h0, 3,-1);
        // Only filter 2 ready; strobes in idle are dropped; selection holds after ready drops
        add(0,1,1,4'h4,0,0,4'h0,-1,-1);
        add(0,1,0,4'h4,0,0,4'h0, 2,-1);
        add(0,1,0,4'h0,0,0,4'h0, 2,-1);
        add(0,0,1,4'h0,0,0,4'h0, 2,-1);
        add(0,0,0,4'h0,0,0,4'h0,-1,-1);
        // Egress: filters 1 and 3 ready -> grant 1 then 3; done in idle ignored
        add(0,0,0,4'h0,0,1,4'hA,-1,-1);
        add(0,0,0,4'h0,1,0,4'hA,-1, 1);
        add(0,0,0,4'h0,0,1,4'hA,-1, 1);
        add(0,0,0,4'h0,0,0,4'hA,-1,-1);
        add(0,0,0,4'h0,1,0,4'hA,-1, 3);
        add(0,0,0,4'h0,0,1,4'h0,-1, 3);
        // Concurrent ingress on 0 and egress on 3, both done together
        add(0,0,0,4'h1,0,0,4'h8,-1,-1);
        add(0,1,0,4'h1,1,0,4'h8, 0, 3);
        add(0,0,1,4'h1,0,1,4'h8, 0, 3);
        add(0,0,0,4'h0,0,0,4'h0,-1,-1);
        // Reset mid-fill after 2 writes; done in the reset cycle is swallowed
        add(0,0,0,4'hF,0,0,4'h0,-1,-1);
        add(0,1,0,4'hF,0,0,4'h0, 1,-1);
        add(0,1,0,4'hF,0,0,4'h0, 1,-1);
        add(1,0,1,4'hF,0,0,4'hF,-1,-1);
        add(0,0,0,4'hF,0,0,4'h0,-1,-1);
        add(0,1,0,4'hF,0,0,4'h0, 0,-1);
        add(0,0,1,4'hF,0,0,4'h0, 0,-1);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("row%0d", i), actual_vec(), expect_vec(tbl[i]));
        end

`ifdef PACKETFILT_SCHED_STATS_EN
        @(negedge clk);
        v = '{rst: 1'b0, wr: 1'b0, sd: 1'b0, rs: 4'h0, rd: 1'b0, fd: 1'b0, rf: 4'h0, ins: -1, egs: -1};
        drive(v);
        #1;
        check("stats_after_reset", {28'd0, pkts_dispatched, pkts_forwarded}, {28'd0, 32'd1, 32'd0});
`endif

        // Reset with all forwarder-ready set: first egress grant after reset goes to filter 0
        @(negedge clk);
        v = '{rst: 1'b1, wr: 1'b0, sd: 1'b0, rs: 4'h0, rd: 1'b0, fd: 1'b1, rf: 4'hF, ins: -1, egs: -1};
        drive(v);
        #1;
        check("rst_cycle", actual_vec(), expect_vec(v));
        @(negedge clk);
        v.rst = 1'b0; v.fd = 1'b0;
        drive(v);
        #1;
        check("eg_idle_post_rst", actual_vec(), expect_vec(v));
        @(negedge clk);
        v.rd = 1'b1; v.egs = 0;
        drive(v);
        #1;
        check("eg_grant0_read", actual_vec(), expect_vec(v));
        @(negedge clk);
        v.rd = 1'b0; v.fd = 1'b1;
        drive(v);
        #1;
        check("eg_grant0_done", actual_vec(), expect_vec(v));
        @(negedge clk);
        v.fd = 1'b0; v.rf = 4'h0; v.egs = -1;
        drive(v);
        #1;
        check("eg_back_idle", actual_vec(), expect_vec(v));
`ifdef PACKETFILT_SCHED_STATS_EN
        check("stats_fwd", {28'd0, pkts_dispatched, pkts_forwarded}, {28'd0, 32'd0, 32'd1});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
